// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the AHB-Lite RAM arbiter.
// Build option: define AHB_ARB_ROUND_ROBIN_EN for round-robin handover; the default is fixed priority.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_MAX_HOLD    = 8;

  localparam logic [7:0] HC_MAX = 8'hFF;

  // Modular increment for cyclic master search; a < 2*n is always true at the call sites.
  function automatic int wrap_idx(input int a, input int n);
    return (a >= n) ? (a - n) : a;
  endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// Next-owner selector: picks a requesting master other than the current owner.
// Build option: AHB_ARB_ROUND_ROBIN_EN selects the first requester after i_cur in cyclic order;
// without it, the lowest-indexed requester (excluding i_cur) wins.
module ahb_arb_picker
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  localparam int IW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IW-1:0]          i_cur,
  output logic [IW-1:0]          o_idx,
  output logic                   o_found
);

  logic [IW-1:0] w_cand;

  // Scan candidates in policy order; the first hit wins, i_cur itself is never chosen.
  always_comb begin
    o_idx   = i_cur;
    o_found = 1'b0;
    w_cand  = i_cur;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k < NUM_MASTERS; k++) begin
      w_cand = IW'(wrap_idx(int'(i_cur) + k, NUM_MASTERS));
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
`else
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_cand = IW'(k);
      if (!o_found && i_req[w_cand] && (w_cand != i_cur)) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
`endif
  end

endmodule

// File: rtl/ahb_ram_arbiter.sv
// AHB-Lite N-master to single RAM slave arbiter with bounded hold per grant.
// Build option: AHB_ARB_ROUND_ROBIN_EN (round-robin handover, else fixed priority).
//
// register | meaning
// r_g      | master owning the address phase (drives S address signals)
// r_d      | master owning the current data phase (drives S_HWDATA)
// r_dv     | a data phase is in flight for r_d
// r_hc     | transfers accepted in the current grant, saturating at 255
module ahb_ram_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [NUM_MASTERS-1:0][31:0] M_HADDR,
  input  logic [NUM_MASTERS-1:0][1:0]  M_HTRANS,
  input  logic [NUM_MASTERS-1:0]       M_HWRITE,
  input  logic [NUM_MASTERS-1:0][2:0]  M_HSIZE,
  input  logic [NUM_MASTERS-1:0][31:0] M_HWDATA,
  output logic [NUM_MASTERS-1:0]       M_HREADY,
  output logic [31:0]                  M_HRDATA,
  output logic [31:0]                  S_HADDR,
  output logic [1:0]                   S_HTRANS,
  output logic                         S_HWRITE,
  output logic [2:0]                   S_HSIZE,
  output logic [31:0]                  S_HWDATA,
  output logic                         S_HREADY,
  input  logic                         S_HREADYOUT,
  input  logic [31:0]                  S_HRDATA,
  output logic [NUM_MASTERS-1:0]       GRANT
);

  localparam int IW = $clog2(NUM_MASTERS);

  logic [IW-1:0]          r_g;
  logic [IW-1:0]          r_d;
  logic                   r_dv;
  logic [7:0]             r_hc;

  logic [IW-1:0]          w_g_nxt;
  logic [IW-1:0]          w_d_nxt;
  logic                   w_dv_nxt;
  logic [7:0]             w_hc_nxt;
  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_gmask;
  logic                   w_others;
  logic [8:0]             w_hc_inc;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_pick_found;

  // Request vector (NONSEQ/SEQ) and one-hot of the current address-phase owner.
  always_comb begin
    w_req   = '0;
    w_gmask = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_req[i]   = M_HTRANS[i][1];
      w_gmask[i] = (IW'(i) == r_g);
    end
    w_others = |(w_req & ~w_gmask);
    w_hc_inc = {1'b0, r_hc} + 9'd1;
  end

  ahb_arb_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .i_req   (w_req),
    .i_cur   (r_g),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // Next-state: everything advances only on an edge where the slave is ready.
  always_comb begin
    w_g_nxt  = r_g;
    w_d_nxt  = r_d;
    w_dv_nxt = r_dv;
    w_hc_nxt = r_hc;
    if (S_HREADYOUT) begin
      w_d_nxt  = r_g;
      w_dv_nxt = M_HTRANS[r_g][1];
      if (M_HTRANS[r_g][1] && ((w_hc_inc < 9'(MAX_HOLD)) || !w_others)) begin
        w_hc_nxt = (r_hc == HC_MAX) ? HC_MAX : w_hc_inc[7:0];
      end else begin
        w_hc_nxt = '0;
        if (w_pick_found) begin
          w_g_nxt = w_pick_idx;
        end
      end
    end
  end

  // State register with synchronous active-low reset; reset drops any in-flight data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_g  <= '0;
      r_d  <= '0;
      r_dv <= 1'b0;
      r_hc <= '0;
    end else begin
      r_g  <= w_g_nxt;
      r_d  <= w_d_nxt;
      r_dv <= w_dv_nxt;
      r_hc <= w_hc_nxt;
    end
  end

  // Bus muxing and per-master ready: owner of either phase sees the slave's ready.
  always_comb begin
    S_HADDR  = M_HADDR[r_g];
    S_HTRANS = M_HTRANS[r_g];
    S_HWRITE = M_HWRITE[r_g];
    S_HSIZE  = M_HSIZE[r_g];
    S_HWDATA = M_HWDATA[r_d];
    M_HRDATA = S_HRDATA;
    S_HREADY = S_HREADYOUT;
    GRANT    = w_gmask;
    M_HREADY = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      M_HREADY[i] = S_HREADYOUT && (w_gmask[i] || (r_dv && (IW'(i) == r_d)));
    end
  end

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Self-checking bench for ahb_ram_arbiter with three masters and MAX_HOLD=8.
// Expectations follow the AHB_ARB_ROUND_ROBIN_EN setting of the build.
module tb_ahb_ram_arbiter;
  import ahb_arb_pkg::*;

  localparam int NM = 3;
  localparam int MH = 8;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] NS = 2'b10;

`ifdef AHB_ARB_ROUND_ROBIN_EN
  localparam int         PICK    = 2;
  localparam logic [2:0] PICK_OH = 3'b100;
`else
  localparam int         PICK    = 0;
  localparam logic [2:0] PICK_OH = 3'b001;
`endif

  logic                  HCLK;
  logic                  HRESETn;
  logic [NM-1:0][31:0]   m_haddr;
  logic [NM-1:0][1:0]    m_htrans;
  logic [NM-1:0]         m_hwrite;
  logic [NM-1:0][2:0]    m_hsize;
  logic [NM-1:0][31:0]   m_hwdata;
  logic [NM-1:0]         m_hready;
  logic [31:0]           m_hrdata;
  logic [31:0]           s_haddr;
  logic [1:0]            s_htrans;
  logic                  s_hwrite;
  logic [2:0]            s_hsize;
  logic [31:0]           s_hwdata;
  logic                  s_hready;
  logic                  s_hreadyout;
  logic [31:0]           s_hrdata;
  logic [NM-1:0]         grant;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0] t0;
    logic [1:0] t1;
    logic [1:0] t2;
    logic       rdy;
    int         exp_g;
    logic [2:0] exp_mrdy;
  } vec_t;

  vec_t        vecs[8];
  int          exp_q[$];
  logic [31:0] wd_q[$];

  ahb_ram_arbiter #(
    .NUM_MASTERS (NM),
    .MAX_HOLD    (MH)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .M_HADDR     (m_haddr),
    .M_HTRANS    (m_htrans),
    .M_HWRITE    (m_hwrite),
    .M_HSIZE     (m_hsize),
    .M_HWDATA    (m_hwdata),
    .M_HREADY    (m_hready),
    .M_HRDATA    (m_hrdata),
    .S_HADDR     (s_haddr),
    .S_HTRANS    (s_htrans),
    .S_HWRITE    (s_hwrite),
    .S_HSIZE     (s_hsize),
    .S_HWDATA    (s_hwdata),
    .S_HREADY    (s_hready),
    .S_HREADYOUT (s_hreadyout),
    .S_HRDATA    (s_hrdata),
    .GRANT       (grant)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + (32'(i) * 32'h100);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_idle();
    for (int i = 0; i < NM; i++) begin
      m_haddr[i]  = addr_of(i);
      m_htrans[i] = ID;
      m_hwrite[i] = 1'b0;
      m_hsize[i]  = 3'b010;
      m_hwdata[i] = 32'hD000_0000 + 32'(i);
    end
    s_hreadyout = 1'b1;
    s_hrdata    = 32'h0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    set_idle();
    next_cycle();
    next_cycle();
    HRESETn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] oh;
    int e;

    vecs[0] = '{ID, ID, ID, 1'b1, 0,    3'b001};
    vecs[1] = '{ID, NS, ID, 1'b1, 0,    3'b001};
    vecs[2] = '{ID, NS, ID, 1'b1, 1,    3'b010};
    vecs[3] = '{ID, ID, ID, 1'b1, 1,    3'b010};
    vecs[4] = '{NS, ID, NS, 1'b1, 1,    3'b010};
    vecs[5] = '{NS, ID, NS, 1'b0, PICK, 3'b000};
    vecs[6] = '{NS, ID, NS, 1'b1, PICK, PICK_OH};
    vecs[7] = '{ID, ID, ID, 1'b1, PICK, PICK_OH};

    // Table-driven cycle sequence starting from reset
    do_reset();
    for (int k = 0; k < 8; k++) begin
      m_htrans[0] = vecs[k].t0;
      m_htrans[1] = vecs[k].t1;
      m_htrans[2] = vecs[k].t2;
      s_hreadyout = vecs[k].rdy;
      s_hrdata    = 32'hA5A5_0000 + 32'(k);
      #4;
      oh = 3'b001 << vecs[k].exp_g;
      check($sformatf("vec%0d grant", k),   32'(grant),    32'(oh));
      check($sformatf("vec%0d mready", k),  32'(m_hready), 32'(vecs[k].exp_mrdy));
      check($sformatf("vec%0d s_htrans", k), 32'(s_htrans), 32'(m_htrans[vecs[k].exp_g]));
      check($sformatf("vec%0d s_haddr", k), s_haddr,       addr_of(vecs[k].exp_g));
      check($sformatf("vec%0d hrdata", k),  m_hrdata,      32'hA5A5_0000 + 32'(k));
      next_cycle();
    end

    // M1 alone writes 0xCAFEF00D to 0x10
    do_reset();
    m_htrans[1] = NS;
    m_hwrite[1] = 1'b1;
    m_haddr[1]  = 32'h0000_0010;
    m_hsize[1]  = 3'b001;
    #4;
    check("wr grant_before", 32'(grant), 32'(3'b001));
    check("wr m1_ready_before", 32'(m_hready[1]), 32'd0);
    next_cycle();
    #4;
    check("wr grant_m1", 32'(grant), 32'(3'b010));
    check("wr s_haddr", s_haddr, 32'h0000_0010);
    check("wr s_hwrite", 32'(s_hwrite), 32'd1);
    check("wr s_hsize", 32'(s_hsize), 32'(3'b001));
    check("wr m1_ready_addr", 32'(m_hready[1]), 32'd1);
    wd_q.push_back(32'hCAFE_F00D);
    next_cycle();
    m_htrans[1] = ID;
    m_hwrite[1] = 1'b0;
    m_hwdata[1] = 32'hCAFE_F00D;
    #4;
    check("wr m1_ready_data", 32'(m_hready[1]), 32'd1);
    check("wr queued", 32'(wd_q.size()), 32'd1);
    if (wd_q.size() > 0) check("wr s_hwdata", s_hwdata, wd_q.pop_front());
    next_cycle();

    // Wait states during M0 data phase must not move the grant
    do_reset();
    m_htrans[0] = NS;
    m_htrans[1] = NS;
    #4;
    check("ws grant_c0", 32'(grant), 32'(3'b001));
    next_cycle();
    m_htrans[0] = ID;
    s_hreadyout = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #4;
      check($sformatf("ws grant_wait%0d", c), 32'(grant), 32'(3'b001));
      check($sformatf("ws m1_ready_wait%0d", c), 32'(m_hready[1]), 32'd0);
      next_cycle();
    end
    s_hreadyout = 1'b1;
    #4;
    check("ws grant_release", 32'(grant), 32'(3'b001));
    check("ws mready_release", 32'(m_hready), 32'(3'b001));
    next_cycle();
    #4;
    check("ws grant_after", 32'(grant), 32'(3'b010));
    check("ws mready_after", 32'(m_hready), 32'(3'b010));
    next_cycle();

    // M0 and M1 request continuously: 8 transfers each, alternating
    do_reset();
    for (int b = 0; b < 4; b++)
      for (int n = 0; n < MH; n++) exp_q.push_back(b % 2);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      m_htrans[0] = NS;
      m_htrans[1] = NS;
      #4;
      if (s_htrans[1] && s_hreadyout) begin
        e = exp_q.pop_front();
        check($sformatf("alt xfer%0d owner", c), s_haddr, addr_of(e));
      end
      next_cycle();
    end
    check("alt drained", 32'(exp_q.size()), 32'd0);

    // Reset while M1 owns a data phase
    do_reset();
    m_htrans[1] = NS;
    next_cycle();
    #4;
    check("rst grant_m1", 32'(grant), 32'(3'b010));
    next_cycle();
    HRESETn = 1'b0;
    #4;
    check("rst m1_dataphase", 32'(m_hready), 32'(3'b010));
    next_cycle();
    HRESETn = 1'b1;
    #4;
    check("rst grant_after", 32'(grant), 32'(3'b001));
    check("rst mready_after", 32'(m_hready), 32'(3'b001));
    next_cycle();

    // Hold counter saturates: after 259 lone M0 transfers a competitor wins at once
    do_reset();
    m_htrans[0] = NS;
    repeat (259) next_cycle();
    m_htrans[1] = NS;
    #4;
    check("sat grant_m0", 32'(grant), 32'(3'b001));
    next_cycle();
    #4;
    check("sat grant_m1", 32'(grant), 32'(3'b010));
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
